// File: rtl/fifo_v4_ctrl.sv
// Control path for fifo_v4: pointers, usage count, handshakes and status flags.
// Storage lives in the parent; this block only says where and when to write/read.
module fifo_v4_ctrl #(
    parameter int unsigned DEPTH        = 8,
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic [ADDR_DEPTH:0]   alm_full_thresh_i,
    input  logic [ADDR_DEPTH:0]   alm_empty_thresh_i,
    output logic [ADDR_DEPTH:0]   usage_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  alm_full_o,
    output logic                  alm_empty_o,
    output logic                  we_o,
    output logic [ADDR_DEPTH-1:0] wr_ptr_o,
    output logic [ADDR_DEPTH-1:0] rd_ptr_o,
    output logic                  bypass_o
);

    localparam logic [ADDR_DEPTH:0]   FifoDepth = DEPTH[ADDR_DEPTH:0];
    localparam logic [ADDR_DEPTH:0]   CntOne    = 1;
    localparam logic [ADDR_DEPTH-1:0] PtrOne    = 1;
    localparam logic [ADDR_DEPTH-1:0] LastPtr   = ADDR_DEPTH'(DEPTH - 1);

    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    logic                  push, pop, is_empty;

    // Explicit wrap so non-power-of-two depths work; DEPTH=1 keeps pointers at 0.
    function automatic logic [ADDR_DEPTH-1:0] next_ptr(input logic [ADDR_DEPTH-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrOne;
    endfunction

    always_comb begin
        is_empty = (cnt_q == '0);
        full_o   = (cnt_q == FifoDepth);
        ready_o  = ~full_o;
        bypass_o = FALL_THROUGH && is_empty && valid_i;
        valid_o  = ~is_empty || bypass_o;
        // A fall-through element taken in the same cycle never touches storage.
        push     = valid_i && ready_o && !(bypass_o && ready_i);
        pop      = valid_o && ready_i && !is_empty;
        we_o     = push && !clr_i && !flush_i;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (clr_i || flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CntOne;
                2'b01:   cnt_d = cnt_q - CntOne;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        usage_o     = cnt_q;
        empty_o     = is_empty;
        alm_full_o  = (cnt_q >= alm_full_thresh_i);
        alm_empty_o = (cnt_q <= alm_empty_thresh_i);
        wr_ptr_o    = wr_ptr_q;
        rd_ptr_o    = rd_ptr_q;
    end

    depth_nonzero_a : assert property (@(posedge clk_i) DEPTH > 0);
    cnt_bound_a : assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= FifoDepth);

endmodule

// File: rtl/fifo_v4.sv
// Synchronous ready/valid FIFO with run-time almost-full/empty thresholds,
// arbitrary depth and optional fall-through.
module fifo_v4 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                flush_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  dtype                data_i,
    output logic                valid_o,
    input  logic                ready_i,
    output dtype                data_o,
    input  logic [ADDR_DEPTH:0] alm_full_thresh_i,
    input  logic [ADDR_DEPTH:0] alm_empty_thresh_i,
    output logic [ADDR_DEPTH:0] usage_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                alm_full_o,
    output logic                alm_empty_o
);

    dtype                  mem_q [DEPTH];
    logic                  we;
    logic                  bypass;
    logic [ADDR_DEPTH-1:0] wr_ptr, rd_ptr;

    fifo_v4_ctrl #(
        .DEPTH        (DEPTH),
        .FALL_THROUGH (FALL_THROUGH),
        .ADDR_DEPTH   (ADDR_DEPTH)
    ) u_ctrl (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .clr_i              (clr_i),
        .flush_i            (flush_i),
        .valid_i            (valid_i),
        .ready_o            (ready_o),
        .valid_o            (valid_o),
        .ready_i            (ready_i),
        .alm_full_thresh_i  (alm_full_thresh_i),
        .alm_empty_thresh_i (alm_empty_thresh_i),
        .usage_o            (usage_o),
        .full_o             (full_o),
        .empty_o            (empty_o),
        .alm_full_o         (alm_full_o),
        .alm_empty_o        (alm_empty_o),
        .we_o               (we),
        .wr_ptr_o           (wr_ptr),
        .rd_ptr_o           (rd_ptr),
        .bypass_o           (bypass)
    );

    // Flush leaves storage alone; only clear wipes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '{default: '0};
        end else if (clr_i) begin
            mem_q <= '{default: '0};
        end else if (we) begin
            mem_q[wr_ptr] <= data_i;
        end
    end

    assign data_o = bypass ? data_i : mem_q[rd_ptr];

    data_stable_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_i && $past(valid_i && !ready_o)) |-> (data_i == $past(data_i)));

endmodule

// File: tb/tb_fifo_v4.sv
// Scoreboard bench for fifo_v4: four configurations driven with directed vectors.
module tb_fifo_v4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // a: DEPTH=5, b: DEPTH=8, c: DEPTH=4 fall-through, d: DEPTH=1
    logic       a_clr = 0, a_flush = 0, a_valid = 0, a_ready = 0;
    logic       a_rdy_o, a_val_o, a_full, a_empty, a_afull, a_aempty;
    logic [7:0] a_data = 0, a_dout;
    logic [3:0] a_aft = 4'd5, a_aet = 4'd0, a_usage;

    logic       b_clr = 0, b_flush = 0, b_valid = 0, b_ready = 0;
    logic       b_rdy_o, b_val_o, b_full, b_empty, b_afull, b_aempty;
    logic [7:0] b_data = 0, b_dout;
    logic [3:0] b_aft = 4'd3, b_aet = 4'd1, b_usage;

    logic       c_clr = 0, c_flush = 0, c_valid = 0, c_ready = 0;
    logic       c_rdy_o, c_val_o, c_full, c_empty, c_afull, c_aempty;
    logic [7:0] c_data = 0, c_dout;
    logic [2:0] c_aft = 3'd0, c_aet = 3'd0, c_usage;

    logic       d_clr = 0, d_flush = 0, d_valid = 0, d_ready = 0;
    logic       d_rdy_o, d_val_o, d_full, d_empty, d_afull, d_aempty;
    logic [7:0] d_data = 0, d_dout;
    logic [1:0] d_aft = 2'd1, d_aet = 2'd0, d_usage;

    fifo_v4 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(5)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(a_clr), .flush_i(a_flush),
        .valid_i(a_valid), .ready_o(a_rdy_o), .data_i(a_data), .valid_o(a_val_o),
        .ready_i(a_ready), .data_o(a_dout), .alm_full_thresh_i(a_aft),
        .alm_empty_thresh_i(a_aet), .usage_o(a_usage), .full_o(a_full),
        .empty_o(a_empty), .alm_full_o(a_afull), .alm_empty_o(a_aempty)
    );

    fifo_v4 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(8)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(b_clr), .flush_i(b_flush),
        .valid_i(b_valid), .ready_o(b_rdy_o), .data_i(b_data), .valid_o(b_val_o),
        .ready_i(b_ready), .data_o(b_dout), .alm_full_thresh_i(b_aft),
        .alm_empty_thresh_i(b_aet), .usage_o(b_usage), .full_o(b_full),
        .empty_o(b_empty), .alm_full_o(b_afull), .alm_empty_o(b_aempty)
    );

    fifo_v4 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(c_clr), .flush_i(c_flush),
        .valid_i(c_valid), .ready_o(c_rdy_o), .data_i(c_data), .valid_o(c_val_o),
        .ready_i(c_ready), .data_o(c_dout), .alm_full_thresh_i(c_aft),
        .alm_empty_thresh_i(c_aet), .usage_o(c_usage), .full_o(c_full),
        .empty_o(c_empty), .alm_full_o(c_afull), .alm_empty_o(c_aempty)
    );

    fifo_v4 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(1)) u_d (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(d_clr), .flush_i(d_flush),
        .valid_i(d_valid), .ready_o(d_rdy_o), .data_i(d_data), .valid_o(d_val_o),
        .ready_i(d_ready), .data_o(d_dout), .alm_full_thresh_i(d_aft),
        .alm_empty_thresh_i(d_aet), .usage_o(d_usage), .full_o(d_full),
        .empty_o(d_empty), .alm_full_o(d_afull), .alm_empty_o(d_aempty)
    );

    logic [7:0] qa[$], qb[$], qc[$], qd[$];

    // Monitors: every accepted output beat is checked against the expected queue.
    always @(negedge clk) begin
        if (rst_n && a_val_o && a_ready) begin
            if (qa.size() == 0) begin
                check("a_unexpected_beat", int'(a_dout), -1);
            end else begin
                check("a_dout", int'(a_dout), int'(qa.pop_front()));
            end
        end
        if (rst_n && b_val_o && b_ready) begin
            if (qb.size() == 0) begin
                check("b_unexpected_beat", int'(b_dout), -1);
            end else begin
                check("b_dout", int'(b_dout), int'(qb.pop_front()));
            end
        end
        if (rst_n && c_val_o && c_ready) begin
            if (qc.size() == 0) begin
                check("c_unexpected_beat", int'(c_dout), -1);
            end else begin
                check("c_dout", int'(c_dout), int'(qc.pop_front()));
            end
        end
        if (rst_n && d_val_o && d_ready) begin
            if (qd.size() == 0) begin
                check("d_unexpected_beat", int'(d_dout), -1);
            end else begin
                check("d_dout", int'(d_dout), int'(qd.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] vals [5];

    initial begin
        vals[0] = 8'hA1; vals[1] = 8'hB2; vals[2] = 8'hC3; vals[3] = 8'hD4; vals[4] = 8'hE5;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Reset state
        check("a_rst_ready", int'(a_rdy_o), 1);
        check("a_rst_valid", int'(a_val_o), 0);
        check("a_rst_empty", int'(a_empty), 1);
        check("a_rst_full", int'(a_full), 0);
        check("a_rst_usage", int'(a_usage), 0);
        check("a_rst_aempty", int'(a_aempty), 1);
        check("a_rst_afull", int'(a_afull), 0);
        check("c_rst_afull_thresh0", int'(c_afull), 1);

        // DEPTH=5: fill, refuse sixth, drain in order
        for (int i = 0; i < 5; i++) begin
            a_valid = 1'b1;
            a_data  = vals[i];
            qa.push_back(vals[i]);
            tick();
        end
        a_valid = 1'b0;
        check("a_full_flag", int'(a_full), 1);
        check("a_full_ready", int'(a_rdy_o), 0);
        check("a_full_usage", int'(a_usage), 5);
        check("a_full_afull", int'(a_afull), 1);
        a_valid = 1'b1;
        a_data  = 8'h66;
        tick();
        a_valid = 1'b0;
        check("a_sixth_refused", int'(a_usage), 5);
        a_ready = 1'b1;
        repeat (5) tick();
        a_ready = 1'b0;
        check("a_drain_empty", int'(a_empty), 1);
        check("a_drain_queue", qa.size(), 0);

        // DEPTH=5: prefill 2 then continuous push+pop across pointer wraps
        a_valid = 1'b1;
        a_data = 8'hF0; qa.push_back(8'hF0); tick();
        a_data = 8'hF1; qa.push_back(8'hF1); tick();
        a_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a_data = 8'h10 + 8'(i);
            qa.push_back(a_data);
            tick();
            check("a_stream_usage", int'(a_usage), 2);
        end
        a_valid = 1'b0;
        repeat (2) tick();
        a_ready = 1'b0;
        check("a_stream_empty", int'(a_empty), 1);
        check("a_stream_queue", qa.size(), 0);

        // Fall-through: same-cycle bypass, then a stored element
        c_valid = 1'b1; c_ready = 1'b1; c_data = 8'h55;
        qc.push_back(8'h55);
        #1;
        check("c_ft_valid", int'(c_val_o), 1);
        check("c_ft_data", int'(c_dout), 8'h55);
        check("c_ft_empty_flag", int'(c_empty), 1);
        tick();
        check("c_ft_usage", int'(c_usage), 0);
        c_ready = 1'b0; c_data = 8'h66;
        qc.push_back(8'h66);
        #1;
        check("c_ft_data2", int'(c_dout), 8'h66);
        tick();
        c_valid = 1'b0;
        check("c_ft_stored_usage", int'(c_usage), 1);
        check("c_ft_stored_empty", int'(c_empty), 0);
        c_ready = 1'b1;
        tick();
        c_ready = 1'b0;
        check("c_ft_drain_empty", int'(c_empty), 1);
        check("c_ft_queue", qc.size(), 0);

        // DEPTH=8 thresholds: full=3, empty=1
        check("b_rst_afull", int'(b_afull), 0);
        check("b_rst_aempty", int'(b_aempty), 1);
        b_valid = 1'b1;
        b_data = 8'h31; qb.push_back(8'h31); tick();
        check("b_u1_aempty", int'(b_aempty), 1);
        check("b_u1_afull", int'(b_afull), 0);
        b_data = 8'h32; qb.push_back(8'h32); tick();
        check("b_u2_aempty", int'(b_aempty), 0);
        check("b_u2_afull", int'(b_afull), 0);
        b_data = 8'h33; qb.push_back(8'h33); tick();
        b_valid = 1'b0;
        check("b_u3_afull", int'(b_afull), 1);
        b_aft = 4'd4;
        #1;
        check("b_thresh_change", int'(b_afull), 0);
        b_valid = 1'b1;
        b_data = 8'h34; qb.push_back(8'h34); tick();
        check("b_u4_usage", int'(b_usage), 4);

        // Flush with simultaneous push: count cleared, storage kept
        b_flush = 1'b1; b_data = 8'h99;
        tick();
        b_flush = 1'b0; b_valid = 1'b0;
        qb.delete();
        check("b_flush_usage", int'(b_usage), 0);
        check("b_flush_valid", int'(b_val_o), 0);
        check("b_flush_mem_kept", int'(b_dout), 8'h31);

        // Clear with simultaneous push: storage zeroed
        b_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_data = 8'h41 + 8'(i);
            tick();
        end
        b_clr = 1'b1; b_data = 8'hAA;
        tick();
        b_clr = 1'b0; b_valid = 1'b0;
        check("b_clr_usage", int'(b_usage), 0);
        check("b_clr_valid", int'(b_val_o), 0);
        check("b_clr_mem_zero", int'(b_dout), 0);

        // Threshold above DEPTH never asserts almost-full, even when full
        b_aft = 4'd9;
        b_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b_data = 8'h50 + 8'(i);
            qb.push_back(b_data);
            tick();
        end
        b_valid = 1'b0;
        check("b_full_flag", int'(b_full), 1);
        check("b_full_usage", int'(b_usage), 8);
        check("b_full_ready", int'(b_rdy_o), 0);
        check("b_thresh9_afull", int'(b_afull), 0);
        b_ready = 1'b1;
        repeat (8) tick();
        b_ready = 1'b0;
        check("b_drain_empty", int'(b_empty), 1);
        check("b_drain_queue", qb.size(), 0);

        // DEPTH=1: full, pop+push refused, then accepted
        d_valid = 1'b1; d_data = 8'hD1; qd.push_back(8'hD1);
        tick();
        d_valid = 1'b0;
        check("d_full", int'(d_full), 1);
        check("d_usage1", int'(d_usage), 1);
        d_valid = 1'b1; d_ready = 1'b1; d_data = 8'hD2;
        #1;
        check("d_full_ready", int'(d_rdy_o), 0);
        tick();
        check("d_pop_refused_usage", int'(d_usage), 0);
        check("d_ready_back", int'(d_rdy_o), 1);
        d_ready = 1'b0;
        qd.push_back(8'hD2);
        tick();
        d_valid = 1'b0;
        check("d_accept_usage", int'(d_usage), 1);
        d_ready = 1'b1;
        tick();
        d_ready = 1'b0;
        check("d_drain_empty", int'(d_empty), 1);
        check("d_drain_queue", qd.size(), 0);

        // Asynchronous reset mid-transfer drops state at once
        a_valid = 1'b1;
        a_data = 8'h77; tick();
        a_data = 8'h78; tick();
        a_valid = 1'b0;
        check("a_pre_reset_usage", int'(a_usage), 2);
        #2 rst_n = 1'b0;
        #1;
        check("a_async_rst_usage", int'(a_usage), 0);
        check("a_async_rst_valid", int'(a_val_o), 0);
        qa.delete();
        tick();
        rst_n = 1'b1;
        tick();
        check("a_post_rst_empty", int'(a_empty), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
